// File: rtl/usb_out_sequencer_if.sv
// Packet-event and handshake bundle between the USB receiver/transmitter side
// and the bulk OUT sequencer.
interface usb_out_sequencer_if;
    logic       pckt_strobe;
    logic [2:0] pckt_rcvd;
    logic       addr_match;
    logic       crc_ok;
    logic [6:0] fifo_space;
    logic       toggle_clr;
    logic       tx_done;
    logic       rx_en;
    logic       send_ack;
    logic       send_nack;
    logic       commit;
    logic       discard;
    logic       exp_toggle;
    logic       timeout_err;

    modport master (
        output pckt_strobe, pckt_rcvd, addr_match, crc_ok, fifo_space, toggle_clr, tx_done,
        input  rx_en, send_ack, send_nack, commit, discard, exp_toggle, timeout_err
    );

    modport slave (
        input  pckt_strobe, pckt_rcvd, addr_match, crc_ok, fifo_space, toggle_clr, tx_done,
        output rx_en, send_ack, send_nack, commit, discard, exp_toggle, timeout_err
    );
endinterface

// File: rtl/usb_out_sequencer.sv
// Bulk OUT transaction sequencer: pairs OUT tokens with DATA packets, tracks the
// DATA0/DATA1 toggle, decides commit/discard and requests the ACK/NAK handshake.
module usb_out_sequencer #(
    parameter int unsigned MAX_PKT = 64,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic                clk,
    input logic                rst,
    usb_out_sequencer_if.slave bus
);
    localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [6:0]    SPACE_MIN = 7'(MAX_PKT);
    localparam logic [2:0]    PID_OUT   = 3'd1;
    localparam logic [2:0]    PID_DATA0 = 3'd3;
    localparam logic [2:0]    PID_DATA1 = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, HS, WAIT_TX} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          space_ok;
    logic          ack_q, ack_nxt;
    logic          tog;
    logic          commit_q, discard_q, ack_out, nack_out;
    logic          commit_nxt, discard_nxt, flip, latch_out, tmo;
    logic          is_data, pid_bit;

    assign is_data = (bus.pckt_rcvd == PID_DATA0) || (bus.pckt_rcvd == PID_DATA1);
    assign pid_bit = (bus.pckt_rcvd == PID_DATA1);

    always_comb begin
        state_nxt   = state;
        ack_nxt     = ack_q;
        commit_nxt  = 1'b0;
        discard_nxt = 1'b0;
        flip        = 1'b0;
        latch_out   = 1'b0;
        tmo         = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.pckt_strobe && bus.pckt_rcvd == PID_OUT && bus.crc_ok && bus.addr_match) begin
                    latch_out = 1'b1;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // A strobe in the final timer cycle takes precedence over the timeout.
                if (bus.pckt_strobe) begin
                    if (!is_data || !bus.crc_ok) begin
                        discard_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else if (pid_bit != tog) begin
                        discard_nxt = 1'b1;
                        ack_nxt     = 1'b1;
                        state_nxt   = HS;
                    end else if (space_ok) begin
                        commit_nxt  = 1'b1;
                        ack_nxt     = 1'b1;
                        flip        = 1'b1;
                        state_nxt   = HS;
                    end else begin
                        discard_nxt = 1'b1;
                        ack_nxt     = 1'b0;
                        state_nxt   = HS;
                    end
                end else if (timer == T_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HS: state_nxt = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            space_ok  <= 1'b0;
            ack_q     <= 1'b0;
            tog       <= 1'b0;
            commit_q  <= 1'b0;
            discard_q <= 1'b0;
            ack_out   <= 1'b0;
            nack_out  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_q     <= ack_nxt;
            commit_q  <= commit_nxt;
            discard_q <= discard_nxt;
            ack_out   <= (state == HS) && ack_q;
            nack_out  <= (state == HS) && !ack_q;
            if (latch_out) space_ok <= (bus.fifo_space >= SPACE_MIN);
            // Saturating timer, held at zero outside the data wait.
            if (state == WAIT_DATA) begin
                if (timer != T_LAST) timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if (bus.toggle_clr) tog <= 1'b0;
            else if (flip)      tog <= ~tog;
        end
    end

    assign bus.rx_en       = (state == IDLE) || (state == WAIT_DATA);
    assign bus.send_ack    = ack_out;
    assign bus.send_nack   = nack_out;
    assign bus.commit      = commit_q;
    assign bus.discard     = discard_q;
    assign bus.exp_toggle  = tog;
    assign bus.timeout_err = tmo;
endmodule

// File: tb/tb_usb_out_sequencer.sv
// Self-checking bench for usb_out_sequencer: transaction-level reference model,
// directed scenarios followed by randomized OUT/DATA transactions.
module tb_usb_out_sequencer;
    localparam int unsigned MAXP = 64;
    localparam int unsigned TMO  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_out_sequencer_if bus();

    usb_out_sequencer #(.MAX_PKT(MAXP), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic        m_tog   = 1'b0;

    int unsigned n_commit = 0, n_discard = 0, n_ack = 0, n_nack = 0, n_tmo = 0;
    int unsigned t_commit = 0, t_discard = 0, t_ack = 0, t_nack = 0, t_tmo = 0;
    int unsigned n_both_hs = 0, n_both_cd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log, sampled mid-cycle with the cycle number it appeared in.
    always @(negedge clk) begin
        if (bus.commit)      begin n_commit++;  t_commit  = cyc; end
        if (bus.discard)     begin n_discard++; t_discard = cyc; end
        if (bus.send_ack)    begin n_ack++;     t_ack     = cyc; end
        if (bus.send_nack)   begin n_nack++;    t_nack    = cyc; end
        if (bus.timeout_err) begin n_tmo++;     t_tmo     = cyc; end
        if (bus.send_ack && bus.send_nack) n_both_hs++;
        if (bus.commit && bus.discard)     n_both_cd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic strobe(input logic [2:0] t, input logic am, input logic ck);
        bus.pckt_strobe = 1'b1;
        bus.pckt_rcvd   = t;
        bus.addr_match  = am;
        bus.crc_ok      = ck;
        tick();
        bus.pckt_strobe = 1'b0;
        bus.pckt_rcvd   = 3'd0;
        bus.addr_match  = 1'b0;
        bus.crc_ok      = 1'b0;
    endtask

    // One OUT token followed gap cycles later by a packet of type dt.
    task automatic txn(input logic am, input logic tok_crc, input int space, input int gap,
                       input logic [2:0] dt, input logic dcrc, input int space2,
                       input logic clr, input logic rst_wtx);
        int unsigned cd, s_c, s_d, s_a, s_n, s_t;
        int          e_c, e_d, e_a, e_n;
        logic        hs;
        s_c = n_commit; s_d = n_discard; s_a = n_ack; s_n = n_nack; s_t = n_tmo;
        e_c = 0; e_d = 0; e_a = 0; e_n = 0;

        bus.fifo_space = 7'(space);
        strobe(3'd1, am, tok_crc);
        bus.fifo_space = 7'(space2);
        if (gap > 1) tick(gap - 1);
        cd = cyc;
        bus.toggle_clr = clr;
        strobe(dt, 1'b0, dcrc);
        bus.toggle_clr = 1'b0;

        if (am && tok_crc) begin
            if (!(dt == 3'd3 || dt == 3'd4) || !dcrc) e_d = 1;
            else if ((dt == 3'd4) != m_tog)          begin e_d = 1; e_a = 1; end
            else if (space >= int'(MAXP))             begin e_c = 1; e_a = 1; m_tog = !m_tog; end
            else                                      begin e_d = 1; e_n = 1; end
        end
        if (clr) m_tog = 1'b0;
        hs = (e_a != 0) || (e_n != 0);

        check("rx_en_after_data", bus.rx_en, !hs);
        tick();
        if (hs) begin
            tick(int'($urandom_range(0, 3)));
            check("rx_en_wait_tx", bus.rx_en, 0);
            if (rst_wtx) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_tog = 1'b0;
                check("rx_en_after_rst", bus.rx_en, 1);
                check("toggle_after_rst", bus.exp_toggle, 0);
            end
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            check("rx_en_after_tx", bus.rx_en, 1);
        end
        tick(2);

        check("n_commit",  n_commit  - s_c, e_c);
        check("n_discard", n_discard - s_d, e_d);
        check("n_ack",     n_ack     - s_a, e_a);
        check("n_nack",    n_nack    - s_n, e_n);
        check("n_timeout", n_tmo     - s_t, 0);
        if (e_c != 0) check("t_commit",  t_commit,  cd + 1);
        if (e_d != 0) check("t_discard", t_discard, cd + 1);
        if (e_a != 0) check("t_ack",     t_ack,     cd + 2);
        if (e_n != 0) check("t_nack",    t_nack,    cd + 2);
        check("exp_toggle", bus.exp_toggle, m_tog);
    endtask

    task automatic timeout_txn();
        int unsigned c0, s_c, s_d, s_a, s_n, s_t;
        s_c = n_commit; s_d = n_discard; s_a = n_ack; s_n = n_nack; s_t = n_tmo;
        bus.fifo_space = 7'd64;
        c0 = cyc;
        strobe(3'd1, 1'b1, 1'b1);
        tick(int'(TMO) - 1);
        check("timeout_live", bus.timeout_err, 1);
        tick();
        check("rx_en_after_tmo", bus.rx_en, 1);
        strobe(m_tog ? 3'd4 : 3'd3, 1'b0, 1'b1);
        tick(3);
        check("n_timeout_tmo", n_tmo     - s_t, 1);
        check("t_timeout",     t_tmo,     c0 + TMO);
        check("n_commit_tmo",  n_commit  - s_c, 0);
        check("n_discard_tmo", n_discard - s_d, 0);
        check("n_ack_tmo",     n_ack     - s_a, 0);
        check("n_nack_tmo",    n_nack    - s_n, 0);
        check("toggle_tmo",    bus.exp_toggle, m_tog);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pckt_strobe = 1'b0;
        bus.pckt_rcvd   = 3'd0;
        bus.addr_match  = 1'b0;
        bus.crc_ok      = 1'b0;
        bus.fifo_space  = 7'd64;
        bus.toggle_clr  = 1'b0;
        bus.tx_done     = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        check("rst_rx_en",   bus.rx_en, 1);
        check("rst_toggle",  bus.exp_toggle, 0);
        check("rst_commit",  bus.commit, 0);
        check("rst_discard", bus.discard, 0);
        check("rst_ack",     bus.send_ack, 0);
        check("rst_nack",    bus.send_nack, 0);
        check("rst_tmo",     bus.timeout_err, 0);

        // commit, duplicate, stale-space NAK, timeout, bad CRC, unmatched OUT
        txn(1'b1, 1'b1, 64, 3, 3'd3, 1'b1, 64, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 64, 2, 3'd3, 1'b1, 64, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 63, 4, 3'd4, 1'b1, 64, 1'b0, 1'b0);
        timeout_txn();
        txn(1'b1, 1'b1, 64, 1, 3'd3, 1'b0, 64, 1'b0, 1'b0);
        txn(1'b0, 1'b1, 64, 2, 3'd4, 1'b1, 64, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 64, 2, 3'd4, 1'b1, 64, 1'b0, 1'b0);
        // toggle_clr against a committing flip, then reset while awaiting tx_done
        txn(1'b1, 1'b1, 64, 2, 3'd4, 1'b1, 64, 1'b1, 1'b0);
        txn(1'b1, 1'b1, 64, 2, 3'd3, 1'b1, 64, 1'b0, 1'b1);
        // DATA arriving in the timeout cycle itself
        txn(1'b1, 1'b1, 64, int'(TMO), m_tog ? 3'd4 : 3'd3, 1'b1, 64, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] dt;
            if ($urandom_range(0, 9) < 7) dt = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd3;
            else                          dt = 3'($urandom_range(0, 7));
            txn($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                int'($urandom_range(56, 64)), int'($urandom_range(1, 12)), dt,
                $urandom_range(0, 6) != 0, int'($urandom_range(0, 64)),
                $urandom_range(0, 9) == 0, 1'b0);
        end

        check("ack_nack_overlap",      n_both_hs, 0);
        check("commit_discard_overlap", n_both_cd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
